// File: rtl/fp_mul_share_arbiter_pkg.sv
// Shared types and constants for the fp multiplier share arbiter.
// Optional statistics counters are enabled with FP_ARB_STATS_EN.
package fp_arb_pkg;

  localparam int FP_W = 32;
  localparam logic [31:0] FP_ONE = 32'h3F800000;
  localparam int TAG_MAX_W = 3;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
  } tag_ent_t;

  // Index width for n requesters, never below one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((32'sd1 << w) < n) begin
      w = w + 32'sd1;
    end
    return w;
  endfunction

endpackage

// File: rtl/fp_mul_share_arbiter_if.sv
// Requester and multiplier-side bus of the fp multiplier share arbiter.
// grant_cnt exists only when FP_ARB_STATS_EN is defined.
interface fp_mul_share_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 32
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ*W-1:0] rsp_data;
  logic [W-1:0]      mul_a;
  logic [W-1:0]      mul_b;
  logic              mul_valid_in;
  logic [W-1:0]      mul_result;
  logic              mul_valid_out;
  logic              seq_err;
`ifdef FP_ARB_STATS_EN
  logic [NREQ*16-1:0] grant_cnt;
`endif

  modport master (
    output req_valid, req_a, req_b, mul_result, mul_valid_out,
    input  req_ready, rsp_valid, rsp_data, mul_a, mul_b, mul_valid_in, seq_err
`ifdef FP_ARB_STATS_EN
    , input grant_cnt
`endif
  );

  modport slave (
    input  req_valid, req_a, req_b, mul_result, mul_valid_out,
    output req_ready, rsp_valid, rsp_data, mul_a, mul_b, mul_valid_in, seq_err
`ifdef FP_ARB_STATS_EN
    , output grant_cnt
`endif
  );
endinterface

// File: rtl/fp_mul_share_arbiter_tag_delay.sv
// LAT-deep {valid, tag} shift register that tracks ops inside the shared multiplier.
module arb_tag_delay
  import fp_arb_pkg::*;
#(
  parameter int LAT = 4
) (
  input  logic     clk,
  input  logic     reset_global,
  input  tag_ent_t i_ent,
  output tag_ent_t o_ent
);

  tag_ent_t r_pipe [LAT];

  // Shift one stage per cycle; reset drops every in-flight tag.
  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) begin
      for (int i = 0; i < LAT; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0] <= i_ent;
      for (int i = 1; i < LAT; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_ent = r_pipe[LAT-1];

endmodule

// File: rtl/fp_mul_share_arbiter.sv
// Round-robin time-sharing of one pipelined fp multiplier with tag-based result return.
// Define FP_ARB_STATS_EN to add per-requester stall counters (grant_cnt).
module fp_mul_share_arbiter
  import fp_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LAT  = 4,
  parameter int W    = FP_W
) (
  input logic                 clk,
  input logic                 reset_global,
  fp_mul_share_arbiter_if.slave bus
);

  localparam int TW = clog2(NREQ);
  localparam int MW = $clog2(LAT + 1);

  logic [TW-1:0]     r_ptr;
  logic [NREQ-1:0]   r_busy;
  logic [NREQ-1:0]   r_rsp_valid;
  logic [NREQ*W-1:0] r_rsp_data;
  logic [W-1:0]      r_mul_a;
  logic [W-1:0]      r_mul_b;
  logic              r_mul_valid;
  logic              r_seq_err;
  logic [MW-1:0]     r_mask_cnt;
  tag_ent_t          r_issue;
  tag_ent_t          w_tag_out;
  logic [NREQ-1:0]   w_grant;
  logic              w_gnt_any;
  logic [TW-1:0]     w_gnt_idx;
  logic [TW-1:0]     w_scan;

  // First eligible requester at or after the pointer, wrapping.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_grant   = '0;
    w_scan    = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_scan = TW'((int'(r_ptr) + k) % NREQ);
      if (!w_gnt_any && bus.req_valid[w_scan] && !r_busy[w_scan]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_scan;
      end else begin
        w_gnt_idx = w_gnt_idx;
      end
    end
    if (w_gnt_any && !reset_global) begin
      w_grant[w_gnt_idx] = 1'b1;
    end else begin
      w_grant = '0;
    end
  end

  // Issue stage: operands, strobe, pointer advance and tag entry.
  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) begin
      r_ptr       <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_mul_valid <= 1'b0;
      r_issue     <= '0;
    end else begin
      r_mul_valid   <= |w_grant;
      r_issue.valid <= |w_grant;
      r_issue.tag   <= TAG_MAX_W'(w_gnt_idx);
      if (|w_grant) begin
        r_mul_a <= bus.req_a[int'(w_gnt_idx)*W +: W];
        r_mul_b <= bus.req_b[int'(w_gnt_idx)*W +: W];
        r_ptr   <= (int'(w_gnt_idx) == NREQ - 1) ? '0 : w_gnt_idx + TW'(1);
      end else begin
        r_ptr <= r_ptr;
      end
    end
  end

  arb_tag_delay #(.LAT(LAT)) u_tag_delay (
    .clk          (clk),
    .reset_global (reset_global),
    .i_ent        (r_issue),
    .o_ent        (w_tag_out)
  );

  // Retire routes the result to its tag; a requester is never retired and granted together.
  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) begin
      r_busy      <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (w_tag_out.valid && int'(w_tag_out.tag) == i) begin
          r_rsp_data[i*W +: W] <= bus.mul_result;
          r_rsp_valid[i]       <= 1'b1;
          r_busy[i]            <= 1'b0;
        end else begin
          r_rsp_valid[i] <= 1'b0;
          if (w_grant[i]) begin
            r_busy[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Sticky sequence check, masked for LAT cycles after reset so stale pulses are ignored.
  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) begin
      r_seq_err  <= 1'b0;
      r_mask_cnt <= MW'(LAT);
    end else if (r_mask_cnt != '0) begin
      r_mask_cnt <= r_mask_cnt - MW'(1);
    end else if (bus.mul_valid_out != w_tag_out.valid) begin
      r_seq_err <= 1'b1;
    end else begin
      r_seq_err <= r_seq_err;
    end
  end

`ifdef FP_ARB_STATS_EN
  logic [NREQ*16-1:0] r_grant_cnt;

  // Saturating count of cycles each requester waited without a grant.
  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) begin
      r_grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && !w_grant[i] && r_grant_cnt[i*16 +: 16] != 16'hFFFF) begin
          r_grant_cnt[i*16 +: 16] <= r_grant_cnt[i*16 +: 16] + 16'd1;
        end
      end
    end
  end

  assign bus.grant_cnt = r_grant_cnt;
`endif

  assign bus.req_ready    = w_grant;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_data     = r_rsp_data;
  assign bus.mul_a        = r_mul_a;
  assign bus.mul_b        = r_mul_b;
  assign bus.mul_valid_in = r_mul_valid;
  assign bus.seq_err      = r_seq_err;

endmodule
